production_sequencer: RTL and testbench

//  Drives one sock-production counter from the stimulus side. Takes an order (sock type, material, pack

---
 rtl/production_sequencer_pkg.sv | 42 ++++
 rtl/production_sequencer_seq_timer.sv | 36 +++
 rtl/production_sequencer.sv | 244 ++++++++++++++++++++++++
 tb/tb_production_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/production_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// production_sequencer_pkg
// Shared definitions for the sock-production sequencer:
//   - seq_state_t : sequencer FSM states (also exported on the debug port)
//   - T_*         : sock-type codes driven on T
//   - PLS_*       : material codes driven on PLS
//   - defaults for feed length, CO timeout and the expected PAC code
//   - is_busy()   : which states count as "order in progress"
// ---------------------------------------------------------------------------
package production_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FEED    = 3'd1,
        S_WAIT_CO = 3'd2,
        S_GAP     = 3'd3,
        S_HOLD    = 3'd4,
        S_DONE    = 3'd5,
        S_ERR     = 3'd6
    } seq_state_t;

    // Sock-type codes (T)
    localparam logic [2:0] T_NONE      = 3'b000;
    localparam logic [2:0] T_TOBILLERO = 3'b001;
    localparam logic [2:0] T_BAJO      = 3'b010;
    localparam logic [2:0] T_MEDIA     = 3'b100;

    // Material codes (PLS)
    localparam logic [1:0] PLS_NONE    = 2'b00;
    localparam logic [1:0] PLS_POLY    = 2'b01;
    localparam logic [1:0] PLS_ALGODON = 2'b10;
    localparam logic [1:0] PLS_LANA    = 2'b11;

    localparam int         FEEDS_PER_PACK_DEFAULT = 3;
    localparam int         CO_TIMEOUT_DEFAULT     = 8;
    localparam logic [2:0] EXP_PAC_DEFAULT        = 3'b011;

    function automatic logic is_busy(input seq_state_t s);
        return (s == S_FEED) || (s == S_WAIT_CO) || (s == S_GAP) || (s == S_HOLD);
    endfunction

endpackage

// File: rtl/production_sequencer_seq_timer.sv
// ---------------------------------------------------------------------------
// production_sequencer_seq_timer  (the sequencer's seq_timer)
// Synchronous-clear up-counter with a terminal flag. Used twice by the
// sequencer: once as the feed-cycle counter and once as the WAIT_CO timeout.
// Ports:
//   clk   in  clock
//   reset in  synchronous, active-high
//   clear in  synchronous clear (wins over en)
//   en    in  count enable
//   term  out high while the count equals TERM-1
// The counter holds at TERM-1 instead of wrapping.
// ---------------------------------------------------------------------------
module production_sequencer_seq_timer #(
    parameter int TERM = 3,
    parameter int W    = $clog2(TERM + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic term
);

    logic [W-1:0] count;

    assign term = (count == W'(TERM - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (en && !term) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/production_sequencer.sv
// ---------------------------------------------------------------------------
// production_sequencer
// Drives one sock-production counter: accepts an order (type, material, pack
// count), issues FEEDS_PER_PACK qualified feed cycles per pack on PH/SR/T/PLS,
// waits for the counter's CO/PAC pack-complete, inserts one gap cycle and
// repeats until the order is filled, then pulses done.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   start               accept order_* (only in IDLE, DONE, ERR)
//   order_T/PLS/packs   order contents
//   halt                level: suspend feeding (discards partial pack)
//   CO, PAC             pack-complete and package code from the counter
//   PH, SR, T, PLS      registered feed qualifiers/codes to the counter
//   busy                FEED, WAIT_CO, GAP or HOLD
//   done                one-cycle pulse when the order is filled
//   err                 sticky error (timeout, spurious CO, bad PAC)
//   packs_done          packs completed in the current order
//   pac_last            PAC captured at the last accepted CO
//   state_dbg           current FSM state
//
// Handshake: there is no backpressure. start is a one-cycle request that is
// sampled only in IDLE/DONE/ERR; CO is a one-cycle strobe, and PAC is
// meaningful only in the cycle CO is high.
//
// Optional build macro: SEQ_PAC_CHECK_EN -- when defined, a CO whose PAC
// differs from EXP_PAC is treated as an error.
// ---------------------------------------------------------------------------
module production_sequencer
    import production_sequencer_pkg::*;
#(
    parameter int         FEEDS_PER_PACK = FEEDS_PER_PACK_DEFAULT,
    parameter int         PW             = 4,
    parameter int         CO_TIMEOUT     = CO_TIMEOUT_DEFAULT,
    parameter logic [2:0] EXP_PAC        = EXP_PAC_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [2:0]    order_T,
    input  logic [1:0]    order_PLS,
    input  logic [PW-1:0] order_packs,
    input  logic          halt,
    input  logic          CO,
    input  logic [2:0]    PAC,
    output logic          PH,
    output logic          SR,
    output logic [2:0]    T,
    output logic [1:0]    PLS,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [PW-1:0] packs_done,
    output logic [2:0]    pac_last,
    output seq_state_t    state_dbg
);

`ifdef SEQ_PAC_CHECK_EN
    localparam bit PAC_CHECK = 1'b1;
`else
    localparam bit PAC_CHECK = 1'b0;
`endif

    seq_state_t    state, next_state;

    logic [2:0]    order_t_q;
    logic [1:0]    order_pls_q;
    logic [PW-1:0] order_packs_q;

    logic          qual_q;
    logic [2:0]    t_q;
    logic [1:0]    pls_q;
    logic          done_q;
    logic          err_q;
    logic [PW-1:0] packs_done_q;
    logic [2:0]    pac_last_q;

    logic          accept;
    logic          done_d;
    logic          err_set;
    logic          capture;
    logic          inc;
    logic          pac_bad;
    logic          feed_term;
    logic          wait_term;
    logic [2:0]    t_src;
    logic [1:0]    pls_src;

    assign pac_bad = PAC_CHECK && (PAC != EXP_PAC);

    // Feed counter: runs only while feeding, cleared whenever the next state
    // is not FEED, so a halted or completed pack always restarts at unit 0.
    production_sequencer_seq_timer #(.TERM(FEEDS_PER_PACK)) u_feed_timer (
        .clk   (clk),
        .reset (reset),
        .clear (next_state != S_FEED),
        .en    (state == S_FEED),
        .term  (feed_term)
    );

    production_sequencer_seq_timer #(.TERM(CO_TIMEOUT)) u_wait_timer (
        .clk   (clk),
        .reset (reset),
        .clear (next_state != S_WAIT_CO),
        .en    (state == S_WAIT_CO),
        .term  (wait_term)
    );

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        done_d     = 1'b0;
        err_set    = 1'b0;
        capture    = 1'b0;
        inc        = 1'b0;

        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    accept = 1'b1;
                    if (order_packs == '0) begin
                        next_state = S_DONE;
                        done_d     = 1'b1;
                    end else begin
                        next_state = S_FEED;
                    end
                end
            end
            S_FEED: begin
                // Spurious CO beats halt: the counter and sequencer disagree.
                if (CO) begin
                    next_state = S_ERR;
                    err_set    = 1'b1;
                end else if (halt) begin
                    next_state = S_HOLD;
                end else if (feed_term) begin
                    next_state = S_WAIT_CO;
                end
            end
            S_WAIT_CO: begin
                // CO on the last allowed cycle still counts.
                if (CO) begin
                    capture = 1'b1;
                    if (pac_bad) begin
                        next_state = S_ERR;
                        err_set    = 1'b1;
                    end else begin
                        inc = 1'b1;
                        if (packs_done_q + 1'b1 == order_packs_q) begin
                            next_state = S_DONE;
                            done_d     = 1'b1;
                        end else begin
                            next_state = S_GAP;
                        end
                    end
                end else if (wait_term) begin
                    next_state = S_ERR;
                    err_set    = 1'b1;
                end
            end
            S_GAP: begin
                if (CO) begin
                    next_state = S_ERR;
                    err_set    = 1'b1;
                end else begin
                    next_state = S_FEED;
                end
            end
            S_HOLD: begin
                if (CO) begin
                    next_state = S_ERR;
                    err_set    = 1'b1;
                end else if (!halt) begin
                    next_state = S_GAP;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // On the accepting edge the latched order is not yet visible, so feed
    // codes are taken straight from the order inputs.
    assign t_src   = accept ? order_T   : order_t_q;
    assign pls_src = accept ? order_PLS : order_pls_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            order_t_q     <= '0;
            order_pls_q   <= '0;
            order_packs_q <= '0;
            qual_q        <= 1'b0;
            t_q           <= T_NONE;
            pls_q         <= PLS_NONE;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            packs_done_q  <= '0;
            pac_last_q    <= '0;
        end else begin
            state  <= next_state;
            done_q <= done_d;

            // Qualifiers follow the decided next state, so they are high for
            // exactly the cycles spent in FEED.
            qual_q <= (next_state == S_FEED);
            t_q    <= (next_state == S_FEED) ? t_src   : T_NONE;
            pls_q  <= (next_state == S_FEED) ? pls_src : PLS_NONE;

            if (accept) begin
                order_t_q     <= order_T;
                order_pls_q   <= order_PLS;
                order_packs_q <= order_packs;
            end

            if (accept) begin
                err_q <= 1'b0;
            end else if (err_set) begin
                err_q <= 1'b1;
            end

            if (accept) begin
                packs_done_q <= '0;
            end else if (inc && (packs_done_q != order_packs_q)) begin
                packs_done_q <= packs_done_q + 1'b1;
            end

            if (capture) begin
                pac_last_q <= PAC;
            end
        end
    end

    assign PH         = qual_q;
    assign SR         = qual_q;
    assign T          = t_q;
    assign PLS        = pls_q;
    assign busy       = is_busy(state);
    assign done       = done_q;
    assign err        = err_q;
    assign packs_done = packs_done_q;
    assign pac_last   = pac_last_q;
    assign state_dbg  = state;

endmodule

// File: tb/tb_production_sequencer.sv
// ---------------------------------------------------------------------------
// tb_production_sequencer
// Self-checking bench for production_sequencer. A behavioural counter model
// answers each run of FEEDS_PER_PACK qualified cycles with a CO/PAC strobe;
// order results are pushed to an expected queue at launch and popped on done.
// ---------------------------------------------------------------------------
module tb_production_sequencer;
    import production_sequencer_pkg::*;

    localparam int PW    = 4;
    localparam int FEEDS = 3;
    localparam int TMO   = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic          start = 1'b0;
    logic [2:0]    order_T = '0;
    logic [1:0]    order_PLS = '0;
    logic [PW-1:0] order_packs = '0;
    logic          halt = 1'b0;
    logic          CO;
    logic [2:0]    PAC;
    logic          PH, SR;
    logic [2:0]    T;
    logic [1:0]    PLS;
    logic          busy, done, err;
    logic [PW-1:0] packs_done;
    logic [2:0]    pac_last;
    seq_state_t    state_dbg;

    production_sequencer #(
        .FEEDS_PER_PACK (FEEDS),
        .PW             (PW),
        .CO_TIMEOUT     (TMO),
        .EXP_PAC        (3'b011)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .order_T     (order_T),
        .order_PLS   (order_PLS),
        .order_packs (order_packs),
        .halt        (halt),
        .CO          (CO),
        .PAC         (PAC),
        .PH          (PH),
        .SR          (SR),
        .T           (T),
        .PLS         (PLS),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .packs_done  (packs_done),
        .pac_last    (pac_last),
        .state_dbg   (state_dbg)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- counter model (CO responder) ----------------
    logic       auto_co  = 1'b1;
    logic [2:0] auto_pac = 3'b011;
    logic       man_co   = 1'b0;
    logic [2:0] man_pac  = '0;
    logic       resp_co  = 1'b0;
    logic       resp_pend = 1'b0;
    int         resp_cnt = 0;

    assign CO  = auto_co ? resp_co : man_co;
    assign PAC = auto_co ? (resp_co ? auto_pac : 3'b000) : man_pac;

    always @(negedge clk) begin
        resp_co = 1'b0;
        if (reset || !auto_co) begin
            resp_cnt  = 0;
            resp_pend = 1'b0;
        end else begin
            if (resp_pend) begin
                resp_co   = 1'b1;
                resp_pend = 1'b0;
            end
            if (PH && SR) begin
                resp_cnt++;
                if (resp_cnt == FEEDS) begin
                    resp_pend = 1'b1;
                    resp_cnt  = 0;
                end
            end else begin
                resp_cnt = 0;
            end
        end
    end

    // ---------------- feed monitor ----------------
    logic [2:0] cur_t   = '0;
    logic [1:0] cur_pls = '0;
    int ph_cycles = 0;
    int code_errs = 0;

    always @(negedge clk) begin
        if (PH) begin
            ph_cycles++;
            if (!SR || T !== cur_t || PLS !== cur_pls) code_errs++;
        end else if (SR || T !== 3'b000 || PLS !== 2'b00) begin
            code_errs++;
        end
    end

    // ---------------- scoreboard ----------------
    logic [PW+2:0] exp_q[$];
    logic [2:0]    exp_pac_last = 3'b000;

    always @(negedge clk) begin
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(1), 32'(0));
            end else begin
                check("done_result", 32'({packs_done, pac_last}), 32'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_order(input logic [2:0] t, input logic [1:0] p, input logic [PW-1:0] n);
        @(negedge clk);
        cur_t       = t;
        cur_pls     = p;
        order_T     = t;
        order_PLS   = p;
        order_packs = n;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
    endtask

    task automatic wait_state(input seq_state_t s, input int budget, input string name);
        for (int i = 0; i < budget && state_dbg != s; i++) @(negedge clk);
        check(name, 32'(state_dbg), 32'(s));
    endtask

    task automatic wait_done(input int budget, input string name);
        for (int i = 0; i < budget && !done; i++) @(negedge clk);
        check(name, 32'(done), 32'(1));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [2:0]    t;
        logic [1:0]    pls;
        logic [PW-1:0] packs;
        logic [PW-1:0] exp_packs;
        int            exp_feeds;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, e0, n;

        vecs[0] = '{T_BAJO,      PLS_POLY,    4'd2,  4'd2,  6};
        vecs[1] = '{T_TOBILLERO, PLS_ALGODON, 4'd1,  4'd1,  3};
        vecs[2] = '{T_NONE,      PLS_NONE,    4'd0,  4'd0,  0};
        vecs[3] = '{3'b111,      PLS_LANA,    4'd3,  4'd3,  9};
        vecs[4] = '{T_MEDIA,     PLS_POLY,    4'd15, 4'd15, 45};

        // ---- reset state ----
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_state", 32'(state_dbg), 32'(S_IDLE));
        check("rst_outs", 32'({PH, SR, T, PLS, busy, done, err}), 32'(0));
        check("rst_packs", 32'({packs_done, pac_last}), 32'(0));

        // ---- table-driven complete orders ----
        for (int i = 0; i < 5; i++) begin
            f0 = ph_cycles;
            e0 = code_errs;
            if (vecs[i].packs != 0) exp_pac_last = 3'b011;
            exp_q.push_back({vecs[i].exp_packs, exp_pac_last});
            run_order(vecs[i].t, vecs[i].pls, vecs[i].packs);
            wait_done(20 * int'(vecs[i].packs) + 4, "order_done");
            @(negedge clk);
            check("done_pulse_clears", 32'(done), 32'(0));
            check("state_done", 32'(state_dbg), 32'(S_DONE));
            check("busy_after", 32'(busy), 32'(0));
            check("feed_cycles", 32'(ph_cycles - f0), 32'(vecs[i].exp_feeds));
            check("feed_codes", 32'(code_errs - e0), 32'(0));
        end

        // ---- WAIT_CO timeout ----
        auto_co = 1'b0;
        run_order(T_BAJO, PLS_POLY, 4'd1);
        wait_state(S_WAIT_CO, 10, "tmo_reach_wait");
        n = 0;
        while (!err && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("tmo_cycles", 32'(n), 32'(TMO));
        check("tmo_state", 32'(state_dbg), 32'(S_ERR));
        check("tmo_quals", 32'({PH, SR, busy}), 32'(0));
        repeat (2) @(negedge clk);
        check("err_sticky", 32'(err), 32'(1));
        auto_co = 1'b1;
        exp_q.push_back({4'd1, 3'b011});
        run_order(T_BAJO, PLS_POLY, 4'd1);
        check("start_clears_err", 32'(err), 32'(0));
        wait_done(30, "tmo_recover_done");

        // ---- halt on 2nd feed cycle for 4 cycles ----
        f0 = ph_cycles;
        e0 = code_errs;
        exp_q.push_back({4'd1, 3'b011});
        run_order(T_BAJO, PLS_ALGODON, 4'd1);
        @(negedge clk);
        halt = 1'b1;
        @(negedge clk);
        check("halt_state", 32'(state_dbg), 32'(S_HOLD));
        check("halt_quals", 32'({PH, SR}), 32'(0));
        repeat (3) @(negedge clk);
        check("halt_busy", 32'(busy), 32'(1));
        halt = 1'b0;
        @(negedge clk);
        check("halt_gap", 32'(state_dbg), 32'(S_GAP));
        wait_done(30, "halt_done");
        check("halt_feeds", 32'(ph_cycles - f0), 32'(2 + FEEDS));
        check("halt_codes", 32'(code_errs - e0), 32'(0));

        // ---- CO pulsed during GAP ----
        auto_co = 1'b0;
        man_pac = 3'b011;
        run_order(T_BAJO, PLS_POLY, 4'd2);
        wait_state(S_WAIT_CO, 10, "gap_reach_wait");
        man_co = 1'b1;
        @(negedge clk);
        man_co = 1'b0;
        check("gap_state", 32'(state_dbg), 32'(S_GAP));
        check("gap_packs", 32'(packs_done), 32'(1));
        man_co = 1'b1;
        @(negedge clk);
        man_co = 1'b0;
        check("gap_co_err", 32'(err), 32'(1));
        check("gap_co_state", 32'(state_dbg), 32'(S_ERR));
        auto_co = 1'b1;

        // ---- unexpected PAC ----
        auto_pac = 3'b001;
`ifdef SEQ_PAC_CHECK_EN
        run_order(T_BAJO, PLS_POLY, 4'd1);
        wait_state(S_ERR, 20, "pac_err_state");
        check("pac_err", 32'(err), 32'(1));
        check("pac_packs_unchanged", 32'(packs_done), 32'(0));
        check("pac_captured", 32'(pac_last), 32'(3'b001));
`else
        exp_q.push_back({4'd1, 3'b001});
        run_order(T_BAJO, PLS_POLY, 4'd1);
        wait_done(20, "pac_accept_done");
        check("pac_no_err", 32'(err), 32'(0));
`endif
        auto_pac = 3'b011;

        // ---- start while busy is ignored ----
        exp_q.push_back({4'd2, 3'b011});
        run_order(T_MEDIA, PLS_LANA, 4'd2);
        order_packs = 4'd9;
        order_T     = 3'b111;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
        wait_done(40, "busy_start_done");
        check("busy_start_err", 32'(err), 32'(0));

        // ---- reset mid-order ----
        run_order(T_BAJO, PLS_POLY, 4'd3);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_state", 32'(state_dbg), 32'(S_IDLE));
        check("midrst_outs", 32'({PH, SR, T, PLS, busy, err}), 32'(0));
        check("midrst_packs", 32'({packs_done, pac_last}), 32'(0));
        repeat (3) @(negedge clk);
        check("midrst_stays_idle", 32'(state_dbg), 32'(S_IDLE));

        check("scoreboard_empty", 32'(exp_q.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
